// File: rtl/seq_shift_add_multiplier.sv
// Purpose: iterative shift-add multiplier, unsigned or two's-complement, WIDTH-bit operands -> 2*WIDTH-bit product.
// Latency: start sampled on edge 0, product in z with a one-cycle done pulse after edge WIDTH; one result per WIDTH+1 cycles.
// Backpressure: start is ignored while busy=1; start held in the done cycle launches the next operation.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, signed_mode  request and mode, sampled together with a/b while not busy
//   a, b                multiplicand / multiplier
//   busy, done, z       iterating flag, one-cycle completion pulse, held product register
module seq_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   z
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH:0]   acc;      // bit 2*WIDTH is the carry slot of the upper-half add
    logic [CW-1:0]      cnt;
    logic               neg;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH:0]   acc_next;
    logic [2*WIDTH-1:0] prod_mag;
    logic               accept;

    // Magnitude of the most negative operand wraps to itself, which is the
    // correct unsigned magnitude 2^(WIDTH-1).
    assign a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

    assign addend    = mplier[0] ? mcand : '0;
    assign upper_sum = acc[2*WIDTH:WIDTH] + {1'b0, addend};
    // Add into the upper half, then shift the whole accumulator right by one;
    // the add carry lands just below the (now zero) top bit.
    assign acc_next  = {1'b0, upper_sum, acc[WIDTH-1:1]};
    assign prod_mag  = acc_next[2*WIDTH-1:0];

    assign accept = start && (state != ST_CALC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            z      <= '0;
        end else begin
            case (state)
                ST_CALC: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        z     <= neg ? -prod_mag : prod_mag;
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin  // ST_IDLE and ST_DONE behave identically on start
                    done <= 1'b0;
                    if (accept) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_CALC;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
module tb_seq_shift_add_multiplier;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] z8;
    // WIDTH=4 instance
    logic        start4 = 1'b0, sm4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4;
    logic [7:0]  z4;
    // WIDTH=16 instance
    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] z16;

    seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .z(z8));
    seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .z(z4));
    seq_shift_add_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .z(z16));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One 8-bit operation from idle; checks latency, busy length and product.
    task automatic op8(input string tag, input logic sm, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [15:0] exp);
        int lat;
        int bcnt;
        sm8 = sm; a8 = ia; b8 = ib; start8 = 1'b1;
        tick();                         // edge 0
        start8 = 1'b0;
        lat = 0;
        bcnt = 0;
        while (!done8 && lat < 20) begin
            if (busy8) bcnt++;
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd8);
        check({tag, "_busy"}, 64'(bcnt), 64'd8);
        check({tag, "_z"}, 64'(z8), 64'(exp));
        tick();
        check({tag, "_done_pulse"}, 64'(done8), 64'd0);
    endtask

    initial begin
        int n;
        int done_seen;
        logic [7:0] exp4;
        logic signed [3:0] s4a, s4b;
        logic signed [15:0] s16a, s16b;
        longint pa, pb;
        logic [31:0] exp16, exp16_next;
        int last_done;
        int k;

        // Reset state
        #12;
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_z", 64'(z8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed 8-bit vectors
        op8("u_ff_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        op8("u_80_02", 1'b0, 8'h80, 8'h02, 16'h0100);
        op8("s_80_80", 1'b1, 8'h80, 8'h80, 16'h4000);
        op8("s_fd_05", 1'b1, 8'hFD, 8'h05, 16'hFFF1);
        op8("s_00_80", 1'b1, 8'h00, 8'h80, 16'h0000);
        op8("s_7f_80", 1'b1, 8'h7F, 8'h80, 16'hC080);
        op8("s_ff_ff", 1'b1, 8'hFF, 8'hFF, 16'h0001);

        // Handshake: restarts at edges 3 and 5 ignored, start held through DONE accepted
        sm8 = 1'b0; a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
        tick(); n = 0;                  // edge 0
        start8 = 1'b0; a8 = 8'h99; b8 = 8'h77; sm8 = 1'b1;
        tick(); n++;                    // edge 1
        tick(); n++;                    // edge 2
        start8 = 1'b1;
        tick(); n++;                    // edge 3
        start8 = 1'b0;
        tick(); n++;                    // edge 4
        start8 = 1'b1;
        tick(); n++;                    // edge 5
        start8 = 1'b0;
        while (!done8 && n < 20) begin tick(); n++; end
        check("hs_first_lat", 64'(n), 64'd8);
        check("hs_first_z", 64'(z8), 64'h03A8);
        sm8 = 1'b0; a8 = 8'h07; b8 = 8'h09; start8 = 1'b1;
        tick(); n++;                    // edge 9: accepted from DONE
        check("hs_b2b_busy", 64'(busy8), 64'd1);
        tick(); n++;
        start8 = 1'b0;
        while (!done8 && n < 40) begin tick(); n++; end
        check("hs_second_lat", 64'(n), 64'd17);
        check("hs_second_z", 64'(z8), 64'h003F);
        tick();

        // Asynchronous reset mid-operation
        sm8 = 1'b0; a8 = 8'h55; b8 = 8'h03; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy8), 64'd0);
        check("arst_done", 64'(done8), 64'd0);
        check("arst_z", 64'(z8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done8) done_seen = 1;
        end
        check("arst_no_done", 64'(done_seen), 64'd0);

        // WIDTH=4 exhaustive, both modes
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    sm4 = m[0]; a4 = i[3:0]; b4 = j[3:0]; start4 = 1'b1;
                    tick();
                    start4 = 1'b0;
                    k = 0;
                    while (!done4 && k < 12) begin tick(); k++; end
                    if (m == 0) begin
                        exp4 = 8'(i * j);
                    end else begin
                        s4a = i[3:0]; s4b = j[3:0];
                        pa = longint'(s4a); pb = longint'(s4b);
                        exp4 = 8'(pa * pb);
                    end
                    check("w4_lat", 64'(k), 64'd4);
                    check("w4_z", 64'(z4), 64'(exp4));
                end
            end
        end

        // WIDTH=16 random, back-to-back with start held high
        for (int m = 0; m < 2; m++) begin
            sm16 = m[0];
            a16 = 16'($urandom); b16 = 16'($urandom);
            s16a = a16; s16b = b16;
            pa = (m == 1) ? longint'(s16a) : longint'(a16);
            pb = (m == 1) ? longint'(s16b) : longint'(b16);
            exp16 = 32'(pa * pb);
            start16 = 1'b1;
            last_done = 0;
            for (int i = 0; i < 100; i++) begin
                k = 0;
                do begin tick(); k++; end while (!done16 && k < 40);
                check("w16_z", 64'(z16), 64'(exp16));
                if (i > 0) check("w16_gap", 64'(cyc - last_done), 64'd17);
                last_done = cyc;
                a16 = 16'($urandom); b16 = 16'($urandom);
                s16a = a16; s16b = b16;
                pa = (m == 1) ? longint'(s16a) : longint'(a16);
                pb = (m == 1) ? longint'(s16b) : longint'(b16);
                exp16_next = 32'(pa * pb);
                exp16 = exp16_next;
                if (i == 99) start16 = 1'b0;
            end
            tick();
        end
        // Corner products at WIDTH=16
        sm16 = 1'b1; a16 = 16'h8000; b16 = 16'h8000; start16 = 1'b1;
        tick(); start16 = 1'b0; k = 0;
        while (!done16 && k < 40) begin tick(); k++; end
        check("w16_minmin", 64'(z16), 64'h40000000);
        tick();
        sm16 = 1'b0; a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
        tick(); start16 = 1'b0; k = 0;
        while (!done16 && k < 40) begin tick(); k++; end
        check("w16_maxmax", 64'(z16), 64'hFFFE0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
